// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_pkg
//  Purpose  : Shared types for the multicycle MIPS main controller: the ALU
//             operation class handed to the ALU decoder and the FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package mips_mc_pkg;

  // Operation class seen by the ALU decoder
  typedef enum logic [2:0] {
    alu_ADD     = 3'd0,
    alu_SUB     = 3'd1,
    alu_regtype = 3'd2,
    alu_SLT     = 3'd3,
    alu_AND     = 3'd4,
    alu_OR      = 3'd5,
    alu_XOR     = 3'd6,
    alu_LU      = 3'd7
  } alu_t;

  // Main controller states
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWR   = 4'd4,
    S_MEMWB   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JEX     = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_ctrl
//  Purpose  : Multicycle main control FSM for the MIPS datapath. Sequences
//             fetch/decode/execute/memory/writeback, drives all datapath mux
//             selects, write enables and the ALU operation class. Memory
//             states stall on mem_ready and a stall watchdog flags
//             mem_timeout (sticky until reset).
//  Revision : 1.0  initial release
// ============================================================================
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter state_t RESET_STATE  = S_FETCH,
  parameter int     MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pcwrite,
  output logic       pcen,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output alu_t       aluop,
  output logic       illegal_op,
  output logic       mem_timeout
);

  // Opcodes understood by the controller
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_slti  = 6'b001010;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_lui   = 6'b001111;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  localparam logic [3:0] c_wait_max = 4'(MEM_WAIT_MAX);
  localparam logic [3:0] c_wait_sat = 4'hF;

  state_t     r_state;
  state_t     w_next_state;
  logic [5:0] r_op;
  logic [3:0] r_wait_cnt;
  logic       r_mem_timeout;
  logic       w_in_mem;

  // States that hold a memory transaction open and may stall
  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                    (r_state == S_MEMWR);

  assign pcen        = pcwrite | (branch & zero);
  assign mem_timeout = r_mem_timeout;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcode snapshot taken in DECODE so later states ignore IR/op changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 6'd0;
    end else if (r_state == S_DECODE) begin
      r_op <= op;
    end
  end

  // Stall counter: cleared on every state change, counts stalled memory cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_next_state != r_state) begin
      r_wait_cnt <= 4'd0;
    end else if (w_in_mem && !mem_ready && (r_wait_cnt != c_wait_sat)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Sticky watchdog flag; a transfer finishing in the limit cycle still flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (w_in_mem && (r_wait_cnt >= c_wait_max)) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Next-state logic and Moore output decode (FETCH/MEMWR qualify on mem_ready)
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = alu_ADD;
    illegal_op   = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite      = 1'b1;
          pcwrite      = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target precomputed while the opcode is examined
        alusrcb = 2'b11;
        case (op)
          c_op_lw, c_op_sw:          w_next_state = S_MEMADR;
          c_op_rtype:                w_next_state = S_RTYPEEX;
          c_op_beq:                  w_next_state = S_BEQEX;
          c_op_j:                    w_next_state = S_JEX;
          c_op_addi, c_op_slti, c_op_andi,
          c_op_ori, c_op_xori, c_op_lui: w_next_state = S_IMMEX;
          default: begin
            illegal_op   = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        w_next_state = (r_op == c_op_sw) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          w_next_state = S_MEMWB;
        end
      end

      S_MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          memwrite     = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      S_MEMWB: begin
        regwrite     = 1'b1;
        memtoreg     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_RTYPEEX: begin
        alusrca      = 1'b1;
        aluop        = alu_regtype;
        w_next_state = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regwrite     = 1'b1;
        regdst       = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BEQEX: begin
        alusrca      = 1'b1;
        aluop        = alu_SUB;
        branch       = 1'b1;
        pcsrc        = 2'b01;
        w_next_state = S_FETCH;
      end

      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (r_op)
          c_op_slti: aluop = alu_SLT;
          c_op_andi: aluop = alu_AND;
          c_op_ori:  aluop = alu_OR;
          c_op_xori: aluop = alu_XOR;
          c_op_lui:  aluop = alu_LU;
          default:   aluop = alu_ADD;
        endcase
        w_next_state = S_IMMWB;
      end

      S_IMMWB: begin
        regwrite     = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JEX: begin
        pcwrite      = 1'b1;
        pcsrc        = 2'b10;
        w_next_state = S_FETCH;
      end

      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback for each instruction and drives the shared ALU's operation class (alu_t aluop) into the ALU decoder, plus all datapath mux selects and write enables.
- Memory states stall on a ready handshake from the unified instruction/data memory.
- Sits between the instruction register opcode field and the datapath/ALU decoder.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (fixed; exposed for bench visibility only).
- MEM_WAIT_MAX, 15, maximum stall cycles in any memory state before mem_timeout is flagged.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op  input  6  opcode field of the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory has completed the current read/write this cycle
- mem_req  output  1  memory access request, held until mem_ready
- pcwrite  output  1  unconditional PC write enable
- pcen  output  1  final PC enable = pcwrite | (branch & zero)
- branch  output  1  BEQ execute cycle
- iord  output  1  0 = PC address, 1 = ALUOut address
- memwrite  output  1  store request qualifier
- irwrite  output  1  instruction register load
- regwrite  output  1  register file write enable
- regdst  output  1  1 = rd, 0 = rt destination
- memtoreg  output  1  1 = memory data to register file
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
- aluop  output  alu_t  operation class to ALU decoder
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- mem_timeout  output  1  sticky until reset; stall exceeded MEM_WAIT_MAX

Behaviour:
- Reset (async, rst_n low): state = FETCH, wait counter = 0, mem_timeout = 0, illegal_op = 0.
- All outputs are combinational Moore decodes of the state; while reset is held they show the FETCH decode.
- Unlisted outputs in any state are 0; aluop defaults to alu_ADD.
- Assertion during reset mid-instruction aborts it immediately, with no partial register or memory write after rst_n rises.

States (outputs; next state):
- FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, aluop=alu_ADD, pcsrc=00.
  - irwrite and pcwrite only in the cycle mem_ready=1.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=alu_ADD (branch target).
  - LW/SW (100011/101011) -> MEMADR; R-type (000000) -> RTYPEEX; BEQ (000100) -> BEQEX; J (000010) -> JEX.
  - ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LUI 001111 -> IMMEX.
  - Any other opcode -> FETCH with illegal_op pulsed this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=alu_ADD. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req, iord=1. Stay until mem_ready, then -> MEMWB.
- MEMWR: mem_req, iord=1. memwrite asserted in the mem_ready cycle only. Stay until mem_ready, then -> FETCH.
- MEMWB: regwrite, regdst=0, memtoreg=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=alu_regtype -> RTYPEWB.
- RTYPEWB: regwrite, regdst=1, memtoreg=0 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=alu_SUB, branch=1, pcsrc=01 -> FETCH.
- IMMEX: alusrca=1, alusrcb=10. aluop by opcode, registered at DECODE:
  - ADDI -> alu_ADD, SLTI -> alu_SLT, ANDI -> alu_AND, ORI -> alu_OR, XORI -> alu_XOR, LUI -> alu_LU.
  - Next state IMMWB.
- IMMWB: regwrite, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcwrite, pcsrc=10 -> FETCH.

Opcode capture and timing:
- The opcode is captured into an internal register at DECODE. Later states use the captured value, so op changes after DECODE are ignored.
- Latency with zero-wait memory, counted in cycles including FETCH:
  - LW 5; SW 4; R-type 4; immediates 4; BEQ 3; J 3.
  - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.

Wait counter:
- 4-bit, cleared on entry to any memory state and incremented each stalled cycle, saturating.
- When it reaches MEM_WAIT_MAX, mem_timeout sets. The FSM keeps waiting; there is no forced exit.
- mem_ready in the same cycle the count hits MAX: the transfer completes and mem_timeout still sets.

Test Plan:
- Reset mid-MEMRD (rst_n low 1 cycle) -> next state FETCH, regwrite never asserts, iord=0, mem_req=1.
- op=000000 with mem_ready tied 1 -> FETCH, DECODE, RTYPEEX (aluop=alu_regtype), RTYPEWB (regwrite=1, regdst=1), back to FETCH; 4 cycles.
- op=100011 with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req=1 and iord=1 throughout, MEMWB regwrite=1 memtoreg=1; total 8 cycles.
- op=000100, zero=1 in BEQEX -> pcen=1, pcsrc=01, aluop=alu_SUB. Repeat with zero=0 -> pcen=0.
- op=001101 (ORI) -> IMMEX aluop=alu_OR, alusrcb=10. Changing op to 000000 during IMMEX leaves aluop=alu_OR.
- op=111111 -> DECODE pulses illegal_op=1 for exactly 1 cycle, then FETCH. With mem_ready held 0 for 16 cycles in FETCH -> mem_timeout=1 and it stays 1 after mem_ready rises.
